sram_arbiter: RTL

- Two-port arbiter and sequencer in front of the 32-bit/16-bit-SRAM controller.
- Port 0 is instruction fetch; port 1 is the MEM-stage load/store.
- Selects one requester, drives the controller's mem_read/mem_write/address/data, tracks its freeze (busy) handshake, and returns read data plus a one-cycle ready pulse.
- Guarantees the controller sees request low on the cycle after busy falls, so no operation is re-triggered by accident.

---
 rtl/sram_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-port (fetch / load-store) arbiter and sequencer in front of
//            the 32-bit-over-16-bit SRAM controller. Optional round-robin tie
//            breaking via macro SRAM_ARB_ROUND_ROBIN_EN (default: port 0 wins).
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              ctrl_read,
  output logic              ctrl_write,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdata,
  input  logic [DATA_W-1:0] ctrl_rdata,
  input  logic              ctrl_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic              r_p0_ready;
  logic              r_p1_ready;

  logic              w_pick;
  logic              w_active;

  // Winner id, only meaningful while in IDLE with at least one request.
  always_comb begin
    w_pick = 1'b0;
    if (p0_req && p1_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      w_pick = ~r_last_grant;
`else
      w_pick = 1'b0;
`endif
    end else if (p1_req) begin
      w_pick = 1'b1;
    end
  end

`ifndef SRAM_ARB_ROUND_ROBIN_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = r_last_grant;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
      r_p0_ready   <= 1'b0;
      r_p1_ready   <= 1'b0;
    end else begin
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            r_grant <= w_pick;
            r_we    <= w_pick ? p1_we    : p0_we;
            r_addr  <= w_pick ? p1_addr  : p0_addr;
            r_wdata <= w_pick ? p1_wdata : p0_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (!ctrl_busy) begin
            if (!r_we) begin
              if (r_grant) r_p1_rdata <= ctrl_rdata;
              else         r_p0_rdata <= ctrl_rdata;
            end
            if (r_grant) r_p1_ready <= 1'b1;
            else         r_p0_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request drops in the very cycle busy falls, so the controller always
  // sees an idle cycle before the next operation can be issued.
  assign w_active   = (r_state == S_ISSUE) || ((r_state == S_WAIT) && ctrl_busy);
  assign ctrl_read  = w_active && !r_we;
  assign ctrl_write = w_active &&  r_we;
  assign ctrl_addr  = r_addr;
  assign ctrl_wdata = r_wdata;

  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;
  assign p0_ready = r_p0_ready;
  assign p1_ready = r_p1_ready;

endmodule
`default_nettype wire
